ip_frame_generator: RTL and testbench

//  Transmit-side counterpart of the sniffer's IP match path: builds an IPv4 header (20 B, no options)

---
 rtl/ip_frame_generator.sv | 168 ++++++++++++++++
 tb/tb_ip_frame_generator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_frame_generator.sv
// IPv4 (20 B, no options) frame generator with incrementing-byte payload, big-endian 32-bit word stream.
// Optional feature: define IPGEN_CSUM_EN to compute the header checksum (otherwise the field is 0).
module ip_frame_generator #(
    parameter logic [7:0]  TTL          = 8'h40,
    parameter logic [7:0]  PROTO        = 8'h11,
    parameter logic [15:0] IDENT_INIT   = 16'h0000,
    parameter logic [7:0]  PAYLOAD_SEED = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] payload_len,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic [3:0]  keep,
    output logic        last,
    output logic        busy,
    output logic        len_err
);

    localparam logic [15:0] MAX_LEN = 16'd65515;

    typedef enum logic [3:0] {
        S_IDLE, S_SUM, S_FOLD, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_PAY
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] src_reg, dst_reg;
    logic [15:0] len_reg;
    logic [15:0] ident_reg;
    logic [15:0] csum_reg;
    logic [15:0] rem_reg;        // payload bytes not yet sent, counted from the current word
    logic [7:0]  byte_base_reg;  // payload byte index of lane 0, mod 256
    logic        len_err_reg;

    logic        accept, reject;
    logic [15:0] total_len;
    logic [31:0] pay_word;
    logic [3:0]  lane_en;

    assign accept    = (state_reg == S_IDLE) && start && (payload_len <= MAX_LEN);
    assign reject    = (state_reg == S_IDLE) && start && (payload_len > MAX_LEN);
    assign total_len = len_reg + 16'd20;
    assign len_err   = len_err_reg;

    // Lane gi carries byte gi of the word; unused trailing lanes are zeroed.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[3-gi]          = rem_reg > 16'(gi);
            assign pay_word[31-8*gi -: 8] = lane_en[3-gi] ? (byte_base_reg + PAYLOAD_SEED + 8'(gi)) : 8'h00;
        end
    endgenerate

`ifdef IPGEN_CSUM_EN
    logic [19:0] sum_reg;
    logic [16:0] fold1;
    logic [16:0] fold2;
    assign fold1 = {1'b0, sum_reg[15:0]} + {13'h0, sum_reg[19:16]};
    assign fold2 = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_out   = 32'h0;
        data_valid = 1'b0;
        keep       = 4'b0000;
        last       = 1'b0;
        busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: if (accept) state_next = S_SUM;
            S_SUM:  state_next = S_FOLD;
            S_FOLD: state_next = S_HDR0;
            S_HDR0: begin
                data_valid = 1'b1;
                keep       = 4'b1111;
                data_out   = {8'h45, 8'h00, total_len};
                if (out_ready) state_next = S_HDR1;
            end
            S_HDR1: begin
                data_valid = 1'b1;
                keep       = 4'b1111;
                data_out   = {ident_reg, 16'h4000};
                if (out_ready) state_next = S_HDR2;
            end
            S_HDR2: begin
                data_valid = 1'b1;
                keep       = 4'b1111;
                data_out   = {TTL, PROTO, csum_reg};
                if (out_ready) state_next = S_HDR3;
            end
            S_HDR3: begin
                data_valid = 1'b1;
                keep       = 4'b1111;
                data_out   = src_reg;
                if (out_ready) state_next = S_HDR4;
            end
            S_HDR4: begin
                data_valid = 1'b1;
                keep       = 4'b1111;
                data_out   = dst_reg;
                last       = (len_reg == 16'd0);
                if (out_ready) state_next = last ? S_IDLE : S_PAY;
            end
            S_PAY: begin
                data_valid = 1'b1;
                keep       = lane_en;
                data_out   = pay_word;
                last       = (rem_reg <= 16'd4);
                if (out_ready) state_next = last ? S_IDLE : S_PAY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_reg       <= 32'h0;
            dst_reg       <= 32'h0;
            len_reg       <= 16'h0;
            ident_reg     <= IDENT_INIT;
            csum_reg      <= 16'h0;
            rem_reg       <= 16'h0;
            byte_base_reg <= 8'h0;
            len_err_reg   <= 1'b0;
`ifdef IPGEN_CSUM_EN
            sum_reg       <= 20'h0;
`endif
        end else begin
            len_err_reg <= reject;
            if (accept) begin
                src_reg       <= src_ip;
                dst_reg       <= dst_ip;
                len_reg       <= payload_len;
                rem_reg       <= payload_len;
                byte_base_reg <= 8'h0;
            end
`ifdef IPGEN_CSUM_EN
            if (state_reg == S_SUM) begin
                sum_reg <= 20'h04500 + {4'h0, total_len} + {4'h0, ident_reg} + 20'h04000
                         + {4'h0, TTL, PROTO}
                         + {4'h0, src_reg[31:16]} + {4'h0, src_reg[15:0]}
                         + {4'h0, dst_reg[31:16]} + {4'h0, dst_reg[15:0]};
            end
            if (state_reg == S_FOLD) csum_reg <= ~fold2[15:0];
`else
            if (state_reg == S_FOLD) csum_reg <= 16'h0000;
`endif
            if (state_reg == S_PAY && out_ready) begin
                rem_reg       <= rem_reg - 16'd4;
                byte_base_reg <= byte_base_reg + 8'd4;
            end
            if (data_valid && out_ready && last) ident_reg <= ident_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_ip_frame_generator.sv
// Directed bench for ip_frame_generator: frame-level model builds expected word queues, a
// per-cycle monitor checks every transfer and stall stability against them.
module tb_ip_frame_generator;

    localparam logic [7:0] TTL  = 8'h40;
    localparam logic [7:0] PROTO = 8'h11;
    localparam int         SEED = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_ip = 32'h0;
    logic [31:0] dst_ip = 32'h0;
    logic [15:0] payload_len = 16'h0;
    logic        out_ready;
    logic [31:0] data_out;
    logic        data_valid;
    logic [3:0]  keep;
    logic        last;
    logic        busy;
    logic        len_err;

    int    tests = 0;
    int    fails = 0;
    int    err_cnt = 0;
    bit    rand_ready = 1'b0;
    word_t frame_q[$];
    word_t exp_q[$];
    logic [15:0] ident_model = 16'h0;

    ip_frame_generator dut (
        .clk(clk), .rst(rst), .start(start), .src_ip(src_ip), .dst_ip(dst_ip),
        .payload_len(payload_len), .out_ready(out_ready), .data_out(data_out),
        .data_valid(data_valid), .keep(keep), .last(last), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Model: whole frame from header fields and payload rules.
    task automatic build_frame(input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] len, input logic [15:0] id);
        int unsigned sum;
        logic [15:0] tl, cs;
        int nw;
        word_t w;
        frame_q.delete();
        tl = len + 16'd20;
`ifdef IPGEN_CSUM_EN
        sum = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'({TTL, PROTO})
            + 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
`else
        sum = 0;
        cs = 16'h0000 | 16'(sum);
`endif
        frame_q.push_back('{d: {8'h45, 8'h00, tl}, k: 4'hF, l: 1'b0});
        frame_q.push_back('{d: {id, 16'h4000},     k: 4'hF, l: 1'b0});
        frame_q.push_back('{d: {TTL, PROTO, cs},   k: 4'hF, l: 1'b0});
        frame_q.push_back('{d: s,                  k: 4'hF, l: 1'b0});
        frame_q.push_back('{d: d,                  k: 4'hF, l: (len == 16'd0)});
        nw = (int'(len) + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                if (wi * 4 + b < int'(len)) begin
                    w.d[31 - 8*b -: 8] = 8'(SEED + wi * 4 + b);
                    w.k[3 - b] = 1'b1;
                end
            end
            w.l = (wi == nw - 1);
            frame_q.push_back(w);
        end
    endtask

    task automatic push_expected();
        foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len);
        build_frame(s, d, len, ident_model);
        push_expected();
        ident_model = ident_model + 16'd1;
        src_ip = s; dst_ip = d; payload_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_complete", 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ident_model = 16'h0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) if (len_err) err_cnt++;

    // Monitor: every transfer against the model queue; held outputs while stalled.
    word_t prev_w;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                if (!data_valid) check("valid_held", 64'(data_valid), 64'd1);
                else check("stall_stable", 64'({data_out, keep, last}), 64'(prev_w));
            end
            if (data_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_word: got %h, want no transfer", {data_out, keep, last});
                end else begin
                    check("word", 64'({data_out, keep, last}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = data_valid && !out_ready;
            prev_w = '{d: data_out, k: keep, l: last};
        end
    end

    initial begin
        int e0;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({data_out, data_valid, keep, last, busy, len_err}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: reference frame with fixed latency
        build_frame(32'hC0A80001, 32'hC0A800C7, 16'd95, 16'h0);
        check("pin_t1_count", 64'(frame_q.size()), 64'd29);
        check("pin_t1_hdr0", 64'(frame_q[0].d), 64'h45000073);
`ifdef IPGEN_CSUM_EN
        check("pin_t1_hdr2", 64'(frame_q[2].d), 64'h4011B861);
`else
        check("pin_t1_hdr2", 64'(frame_q[2].d), 64'h40110000);
`endif
        check("pin_t1_pay0", 64'(frame_q[5].d), 64'h00010203);
        check("pin_t1_lastw", 64'(frame_q[28]), 64'({32'h5C5D5E00, 4'b1110, 1'b1}));
        send(32'hC0A80001, 32'hC0A800C7, 16'd95);
        check("lat_n1", 64'({busy, data_valid}), 64'b10);
        @(posedge clk); #1;
        check("lat_n2", 64'(data_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_n3", 64'(data_valid), 64'd1);
        wait_done(100);

        // 2: empty payload
        build_frame(32'h0A000001, 32'h0A000002, 16'd0, 16'h1);
        check("pin_t2_count", 64'(frame_q.size()), 64'd5);
        check("pin_t2_hdr0", 64'(frame_q[0].d), 64'h45000014);
        check("pin_t2_hdr4", 64'({frame_q[4].k, frame_q[4].l}), 64'b11111);
        send(32'h0A000001, 32'h0A000002, 16'd0);
        wait_done(50);
        check("t2_busy_low", 64'(busy), 64'd0);

        // 3: random backpressure; a start while busy must be ignored silently
        e0 = err_cnt;
        rand_ready = 1'b1;
        send(32'hC0A80001, 32'hC0A800C7, 16'd95);
        repeat (3) @(posedge clk);
        #1;
        payload_len = 16'd65535; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400);
        rand_ready = 1'b0;
        check("busy_start_no_err", 64'(err_cnt - e0), 64'd0);

        // 5: length limit
        @(posedge clk); #1;
        e0 = err_cnt;
        payload_len = 16'd65516; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (data_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rej_idle", 64'(seen), 64'd0);
        check("rej_len_err_pulses", 64'(err_cnt - e0), 64'd1);
        build_frame(32'h01020304, 32'h05060708, 16'd65515, ident_model);
        check("pin_t5_hdr0", 64'(frame_q[0].d), 64'h4500FFFF);
        send(32'h01020304, 32'h05060708, 16'd65515);
        wait_done(20000);

        // 4: back-to-back with start held high
        do_reset();
        build_frame(32'hC0A80001, 32'hC0A800C7, 16'd95, 16'h0);
        push_expected();
        build_frame(32'h0A000001, 32'h0A000002, 16'd7, 16'h1);
        check("pin_t4_hdr1", 64'(frame_q[1].d), 64'h00014000);
        push_expected();
        ident_model = 16'd2;
        src_ip = 32'hC0A80001; dst_ip = 32'hC0A800C7; payload_len = 16'd95; start = 1'b1;
        @(posedge clk); #1;
        src_ip = 32'h0A000001; dst_ip = 32'h0A000002; payload_len = 16'd7;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_idle_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        check("b2b_second_accepted", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(100);

        // 6: reset during payload word 3 abandons the frame
        send(32'hC0A80001, 32'hC0A800C7, 16'd95);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (data_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t6_hdr0_seen", 64'(seen), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("t6_in_pay3", 64'(data_out), 64'h0C0D0E0F);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_abandon", 64'({data_valid, busy, last}), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        ident_model = 16'h0;
        build_frame(32'h0A000003, 32'h0A000004, 16'd8, ident_model);
        check("pin_t6_hdr1", 64'(frame_q[1].d), 64'h00004000);
        send(32'h0A000003, 32'h0A000004, 16'd8);
        wait_done(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
